// File: rtl/word_serializer32.sv
// Parallel-to-serial word shifter with valid/ready serial port.
// Also accumulates AND/OR/XOR summaries of each word as it shifts out.
module word_serializer32 #(
    parameter int WIDTH     = 32,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_bit,
    output logic             ser_last,
    output logic             busy,
    output logic             done,
    output logic             red_and,
    output logic             red_or,
    output logic             red_xor
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_and_acc;
    logic             r_or_acc;
    logic             r_xor_acc;
    logic             r_done;
    logic             r_red_and;
    logic             r_red_or;
    logic             r_red_xor;

    logic             w_shifting;
    logic             w_beat;
    logic             w_last;
    logic             w_fin;
    logic             w_bit;
    logic             w_load;
    logic [WIDTH-1:0] w_shifted;

    assign w_shifting = (r_state == SHIFT);
    assign w_beat     = w_shifting & ser_ready;
    assign w_last     = (r_cnt == LAST);
    assign w_fin      = w_beat & w_last;
    assign w_bit      = LSB_FIRST ? r_shift[0] : r_shift[WIDTH-1];
    assign w_shifted  = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);

    // Ready on the last beat too, so a queued word follows with no bubble.
    assign in_ready = ~reset & (~w_shifting | w_fin);
    assign w_load   = in_valid & in_ready;

    assign ser_valid = w_shifting;
    assign busy      = w_shifting;
    assign ser_bit   = w_bit;
    assign ser_last  = w_shifting & w_last;
    assign done      = r_done;
    assign red_and   = r_red_and;
    assign red_or    = r_red_or;
    assign red_xor   = r_red_xor;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_and_acc <= 1'b0;
            r_or_acc  <= 1'b0;
            r_xor_acc <= 1'b0;
            r_done    <= 1'b0;
            r_red_and <= 1'b0;
            r_red_or  <= 1'b0;
            r_red_xor <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_beat) begin
                r_shift   <= w_shifted;
                r_and_acc <= r_and_acc & w_bit;
                r_or_acc  <= r_or_acc | w_bit;
                r_xor_acc <= r_xor_acc ^ w_bit;
                if (w_last) begin
                    r_red_and <= r_and_acc & w_bit;
                    r_red_or  <= r_or_acc | w_bit;
                    r_red_xor <= r_xor_acc ^ w_bit;
                    r_done    <= 1'b1;
                    r_state   <= IDLE;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            // A load overrides the last-beat bookkeeping above.
            if (w_load) begin
                r_shift   <= in_data;
                r_cnt     <= '0;
                r_and_acc <= 1'b1;
                r_or_acc  <= 1'b0;
                r_xor_acc <= 1'b0;
                r_state   <= SHIFT;
            end
        end
    end

endmodule

// File: doc/word_serializer32.md
Name: word_serializer32

Overview:
- Parallel-to-serial converter: accepts one WIDTH-bit word and emits it one bit per accepted beat on a valid/ready serial port.
- Also reduces the word to single-bit summaries (AND/OR/XOR), accumulated bit-serially while shifting.
- This is the 32-to-1 counterpart of the datapath's 1-to-32 bit-replication logic.
- Serves the debug/trace path next to the register file, and bit-serial peripheral links.

Parameters:
- WIDTH, 32, word width in bits; legal range 2..32.
- LSB_FIRST, 1, 1 = bit 0 shifted out first; 0 = bit WIDTH-1 first.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  word offered
- in_ready  output  1  block can load a word this cycle
- in_data  input  WIDTH  word to serialize
- ser_valid  output  1  ser_bit is valid
- ser_ready  input  1  downstream accepts ser_bit this cycle
- ser_bit  output  1  current serial bit
- ser_last  output  1  high with the final bit of the word
- busy  output  1  word in flight (state SHIFT)
- done  output  1  one-cycle pulse after the last bit is accepted
- red_and  output  1  AND of all bits of the last completed word
- red_or  output  1  OR of all bits of the last completed word
- red_xor  output  1  XOR (parity) of all bits of the last completed word

Behaviour:
- Reset (async, active-high) forces these values immediately:
  - state = IDLE, shift register = 0, bit counter = 0.
  - ser_valid = 0, ser_bit = 0, ser_last = 0, busy = 0, done = 0.
  - red_and = 0, red_or = 0, red_xor = 0.
  - in_ready = 1 once reset deasserts.
- States: IDLE and SHIFT.
- IDLE:
  - in_ready = 1, ser_valid = 0.
  - in_valid = 1 → load in_data into the shift register, clear the counter, seed the accumulators, go to SHIFT.
  - Accumulator seeds: and_acc = 1, or_acc = 0, xor_acc = 0.
- SHIFT:
  - ser_valid = 1, busy = 1.
  - ser_bit = shift register bit 0 (LSB_FIRST = 1) or bit WIDTH-1 (LSB_FIRST = 0).
  - ser_last = (counter == WIDTH-1).
- Beat: a bit is accepted on a cycle with ser_valid & ser_ready. On each beat:
  - Shift the register by one toward the output end.
  - Increment the counter.
  - Update the accumulators: and_acc &= ser_bit, or_acc |= ser_bit, xor_acc ^= ser_bit.
- Stall: ser_ready = 0 holds ser_bit, ser_last, counter and accumulators stable, for any number of cycles.
- Last beat (beat with ser_last = 1):
  - red_and, red_or and red_xor register the final accumulated values, including that last bit.
  - done = 1 on the following cycle, for exactly one cycle.
  - red_* hold their values until the next completion or reset.
- Back-to-back:
  - On the last-beat cycle, in_ready = 1 (combinational: ser_valid & ser_ready & ser_last).
  - If in_valid is also 1, the new word loads and the state stays SHIFT: zero bubble cycles between words.
  - Otherwise return to IDLE.
- Latency:
  - Load cycle to first ser_valid = 1 cycle.
  - A word with ser_ready held high occupies exactly WIDTH cycles.
  - done follows the last accepted bit by 1 cycle.
- in_valid while busy (outside the last-beat cycle): ignored; in_ready = 0, no load, and the in-flight word is not corrupted.
- Counter is $clog2(WIDTH) bits and never exceeds WIDTH-1. Wrap-around occurs only through reload.
- Reset mid-word: the word is aborted, no done pulse is produced, and red_* clear to 0.
- in_data is sampled only on the load cycle; later changes have no effect.

Test Plan:
- LSB_FIRST = 1, in_data = 0x0000_0005, ser_ready = 1 → bits 1,0,1 then 29 zeros over 32 cycles; ser_last on cycle 32; done next cycle; red_and = 0, red_or = 1, red_xor = 0.
- in_data = 0xFFFF_FFFF, then 0x8000_0000 with in_valid held → the second word loads on the last-beat cycle with no gap; red after word 1 = (1,1,0), after word 2 = (0,1,1); exactly two done pulses.
- in_data = 0xA5A5_A5A5, ser_ready toggled 1/0 each cycle → 64 cycles to complete; bit stream matches 0xA5A5_A5A5 LSB-first; ser_bit stable during stalls; red_xor = 0.
- LSB_FIRST = 0, in_data = 0x8000_0001 → first bit 1, then 30 zeros, last bit 1; red_xor = 0.
- Assert reset asynchronously mid-cycle after 10 accepted bits of 0x1234_5678 → outputs clear immediately; no done pulse; after release in_ready = 1, and a fresh word 0x0000_0001 serializes correctly.
- in_valid pulsed with 0xDEAD_BEEF while busy at bit 5 → ignored; the in-flight word completes unchanged.
